// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS pipeline datapath blocks.
// Contents:
//   - ALU operation codes (ALU_AND .. ALU_SLT) as driven on alu_op
//   - Opcode / funct field values understood by the ALU-control decoder
//   - ex_ctrl_t: MEM/WB control bits carried through the ID/EX register
package mips_pkg;

  localparam logic [2:0] ALU_AND = 3'd0;
  localparam logic [2:0] ALU_OR  = 3'd1;
  localparam logic [2:0] ALU_ADD = 3'd2;
  localparam logic [2:0] ALU_SUB = 3'd3;
  localparam logic [2:0] ALU_SLT = 3'd4;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  typedef struct packed {
    logic mem_read;
    logic mem_write;
    logic reg_write;
    logic mem_to_reg;
  } ex_ctrl_t;

endpackage

// File: rtl/alu_ctrl_dec.sv
// ALU-control decoder: maps opcode/funct to a 3-bit ALU operation.
// Ports:
//   opcode  in  6  instruction[31:26]
//   funct   in  6  instruction[5:0]
//   alu_op  out 3  ALU operation code (see mips_pkg ALU_*)
//   illegal out 1  opcode/funct combination not supported
// Unsupported encodings report ALU_ADD so the EX stage still computes
// something well defined while the illegal flag travels downstream.
module alu_ctrl_dec
  import mips_pkg::*;
(
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  output logic [2:0] alu_op,
  output logic       illegal
);

  always_comb begin
    alu_op  = ALU_ADD;
    illegal = 1'b0;
    case (opcode)
      OP_RTYPE: begin
        case (funct)
          FN_AND:  alu_op = ALU_AND;
          FN_OR:   alu_op = ALU_OR;
          FN_ADD:  alu_op = ALU_ADD;
          FN_SUB:  alu_op = ALU_SUB;
          FN_SLT:  alu_op = ALU_SLT;
          default: illegal = 1'b1;
        endcase
      end
      OP_LW, OP_SW, OP_ADDI: alu_op = ALU_ADD;
      OP_BEQ:  alu_op = ALU_SUB;
      OP_ANDI: alu_op = ALU_AND;
      OP_ORI:  alu_op = ALU_OR;
      OP_SLTI: alu_op = ALU_SLT;
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register of the 5-stage MIPS pipeline.
// Latches decoded operands and control from ID, generates alu_op from
// opcode/funct, and presents ALU operands plus MEM/WB control to EX.
// Ports:
//   clk, rst (sync, active high), stall (hold), flush (insert bubble)
//   in_*     ID-stage instruction fields, operands and main-decoder control
//   ex_valid, alu_a, alu_b, alu_op, ex_store_data   EX-stage operands
//   ex_rs, ex_rt, ex_dst                           register addresses
//   ex_mem_read/_write, ex_reg_write, ex_mem_to_reg latched control
//   ex_illegal                                     unsupported instruction
// Optional feature (macro ID_EX_FWD_EN): adds EX/MEM (fwd_m_*) and MEM/WB
// (fwd_w_*) forwarding ports that override the registered rs/rt values.
module id_ex_stage
  import mips_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int REG_W  = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              flush,
  input  logic              in_valid,
  input  logic [5:0]        in_opcode,
  input  logic [5:0]        in_funct,
  input  logic [DATA_W-1:0] in_rs_data,
  input  logic [DATA_W-1:0] in_rt_data,
  input  logic [DATA_W-1:0] in_imm,
  input  logic [REG_W-1:0]  in_rs,
  input  logic [REG_W-1:0]  in_rt,
  input  logic [REG_W-1:0]  in_rd,
  input  logic              in_reg_dst,
  input  logic              in_alu_src,
  input  logic              in_mem_read,
  input  logic              in_mem_write,
  input  logic              in_reg_write,
  input  logic              in_mem_to_reg,
`ifdef ID_EX_FWD_EN
  input  logic              fwd_m_we,
  input  logic [REG_W-1:0]  fwd_m_dst,
  input  logic [DATA_W-1:0] fwd_m_data,
  input  logic              fwd_w_we,
  input  logic [REG_W-1:0]  fwd_w_dst,
  input  logic [DATA_W-1:0] fwd_w_data,
`endif
  output logic              ex_valid,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [2:0]        alu_op,
  output logic [DATA_W-1:0] ex_store_data,
  output logic [REG_W-1:0]  ex_rs,
  output logic [REG_W-1:0]  ex_rt,
  output logic [REG_W-1:0]  ex_dst,
  output logic              ex_mem_read,
  output logic              ex_mem_write,
  output logic              ex_reg_write,
  output logic              ex_mem_to_reg,
  output logic              ex_illegal
);

  logic [2:0]        dec_alu_op;
  logic              dec_illegal;

  logic [DATA_W-1:0] rs_data_q;
  logic [DATA_W-1:0] rt_data_q;
  logic [DATA_W-1:0] imm_q;
  logic              alu_src_q;
  ex_ctrl_t          ctrl_q;

  logic [DATA_W-1:0] rs_val;
  logic [DATA_W-1:0] rt_val;

  alu_ctrl_dec u_dec (
    .opcode  (in_opcode),
    .funct   (in_funct),
    .alu_op  (dec_alu_op),
    .illegal (dec_illegal)
  );

  // Reset and flush both clear everything; a flush wins over stall so a
  // stalled instruction can still be squashed. in_valid=0 loads a bubble.
  always_ff @(posedge clk) begin
    if (rst || flush || (!stall && !in_valid)) begin
      ex_valid   <= 1'b0;
      alu_op     <= ALU_AND;
      ex_illegal <= 1'b0;
      rs_data_q  <= '0;
      rt_data_q  <= '0;
      imm_q      <= '0;
      alu_src_q  <= 1'b0;
      ex_rs      <= '0;
      ex_rt      <= '0;
      ex_dst     <= '0;
      ctrl_q     <= '0;
    end else if (!stall) begin
      ex_valid   <= 1'b1;
      alu_op     <= dec_alu_op;
      ex_illegal <= dec_illegal;
      rs_data_q  <= in_rs_data;
      rt_data_q  <= in_rt_data;
      imm_q      <= in_imm;
      alu_src_q  <= in_alu_src;
      ex_rs      <= in_rs;
      ex_rt      <= in_rt;
      ex_dst     <= in_reg_dst ? in_rd : in_rt;
      // An illegal instruction must not touch memory or the register file.
      ctrl_q.mem_read   <= in_mem_read  && !dec_illegal;
      ctrl_q.mem_write  <= in_mem_write && !dec_illegal;
      ctrl_q.reg_write  <= in_reg_write && !dec_illegal;
      ctrl_q.mem_to_reg <= in_mem_to_reg;
    end
  end

`ifdef ID_EX_FWD_EN
  // EX/MEM result is newer than MEM/WB, so it is checked first.
  // Register 0 is hard-wired to zero and is never forwarded.
  always_comb begin
    rs_val = rs_data_q;
    rt_val = rt_data_q;
    if (ex_valid) begin
      if (fwd_m_we && (fwd_m_dst != '0) && (fwd_m_dst == ex_rs))
        rs_val = fwd_m_data;
      else if (fwd_w_we && (fwd_w_dst != '0) && (fwd_w_dst == ex_rs))
        rs_val = fwd_w_data;
      if (fwd_m_we && (fwd_m_dst != '0) && (fwd_m_dst == ex_rt))
        rt_val = fwd_m_data;
      else if (fwd_w_we && (fwd_w_dst != '0) && (fwd_w_dst == ex_rt))
        rt_val = fwd_w_data;
    end
  end
`else
  assign rs_val = rs_data_q;
  assign rt_val = rt_data_q;
`endif

  assign alu_a         = rs_val;
  assign alu_b         = alu_src_q ? imm_q : rt_val;
  assign ex_store_data = rt_val;

  assign ex_mem_read   = ctrl_q.mem_read;
  assign ex_mem_write  = ctrl_q.mem_write;
  assign ex_reg_write  = ctrl_q.reg_write;
  assign ex_mem_to_reg = ctrl_q.mem_to_reg;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed testbench for id_ex_stage.
// Covers reset, R-type/I-type decode, lw operand selection, stall hold,
// flush/reset priority over stall, bubbles and illegal instructions.
// With ID_EX_FWD_EN defined it also covers the forwarding overrides.
module tb_id_ex_stage;

  localparam int DATA_W = 32;
  localparam int REG_W  = 5;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              stall = 1'b0;
  logic              flush = 1'b0;
  logic              in_valid = 1'b0;
  logic [5:0]        in_opcode = '0;
  logic [5:0]        in_funct = '0;
  logic [DATA_W-1:0] in_rs_data = '0;
  logic [DATA_W-1:0] in_rt_data = '0;
  logic [DATA_W-1:0] in_imm = '0;
  logic [REG_W-1:0]  in_rs = '0;
  logic [REG_W-1:0]  in_rt = '0;
  logic [REG_W-1:0]  in_rd = '0;
  logic              in_reg_dst = 1'b0;
  logic              in_alu_src = 1'b0;
  logic              in_mem_read = 1'b0;
  logic              in_mem_write = 1'b0;
  logic              in_reg_write = 1'b0;
  logic              in_mem_to_reg = 1'b0;
`ifdef ID_EX_FWD_EN
  logic              fwd_m_we = 1'b0;
  logic [REG_W-1:0]  fwd_m_dst = '0;
  logic [DATA_W-1:0] fwd_m_data = '0;
  logic              fwd_w_we = 1'b0;
  logic [REG_W-1:0]  fwd_w_dst = '0;
  logic [DATA_W-1:0] fwd_w_data = '0;
`endif

  logic              ex_valid;
  logic [DATA_W-1:0] alu_a;
  logic [DATA_W-1:0] alu_b;
  logic [2:0]        alu_op;
  logic [DATA_W-1:0] ex_store_data;
  logic [REG_W-1:0]  ex_rs;
  logic [REG_W-1:0]  ex_rt;
  logic [REG_W-1:0]  ex_dst;
  logic              ex_mem_read;
  logic              ex_mem_write;
  logic              ex_reg_write;
  logic              ex_mem_to_reg;
  logic              ex_illegal;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  id_ex_stage #(.DATA_W(DATA_W), .REG_W(REG_W)) dut (
    .clk           (clk),
    .rst           (rst),
    .stall         (stall),
    .flush         (flush),
    .in_valid      (in_valid),
    .in_opcode     (in_opcode),
    .in_funct      (in_funct),
    .in_rs_data    (in_rs_data),
    .in_rt_data    (in_rt_data),
    .in_imm        (in_imm),
    .in_rs         (in_rs),
    .in_rt         (in_rt),
    .in_rd         (in_rd),
    .in_reg_dst    (in_reg_dst),
    .in_alu_src    (in_alu_src),
    .in_mem_read   (in_mem_read),
    .in_mem_write  (in_mem_write),
    .in_reg_write  (in_reg_write),
    .in_mem_to_reg (in_mem_to_reg),
`ifdef ID_EX_FWD_EN
    .fwd_m_we      (fwd_m_we),
    .fwd_m_dst     (fwd_m_dst),
    .fwd_m_data    (fwd_m_data),
    .fwd_w_we      (fwd_w_we),
    .fwd_w_dst     (fwd_w_dst),
    .fwd_w_data    (fwd_w_data),
`endif
    .ex_valid      (ex_valid),
    .alu_a         (alu_a),
    .alu_b         (alu_b),
    .alu_op        (alu_op),
    .ex_store_data (ex_store_data),
    .ex_rs         (ex_rs),
    .ex_rt         (ex_rt),
    .ex_dst        (ex_dst),
    .ex_mem_read   (ex_mem_read),
    .ex_mem_write  (ex_mem_write),
    .ex_reg_write  (ex_reg_write),
    .ex_mem_to_reg (ex_mem_to_reg),
    .ex_illegal    (ex_illegal)
  );

  // Advance one rising edge and settle 1 time unit past it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive one ID-stage instruction (valid) onto the inputs.
  task automatic set_instr(input logic [5:0] op, input logic [5:0] fn,
                           input logic [31:0] rs_d, input logic [31:0] rt_d,
                           input logic [31:0] imm, input logic [4:0] rs,
                           input logic [4:0] rt, input logic [4:0] rd,
                           input logic [5:0] ctl);
    in_valid      = 1'b1;
    in_opcode     = op;
    in_funct      = fn;
    in_rs_data    = rs_d;
    in_rt_data    = rt_d;
    in_imm        = imm;
    in_rs         = rs;
    in_rt         = rt;
    in_rd         = rd;
    // ctl = {reg_dst, alu_src, mem_read, mem_write, reg_write, mem_to_reg}
    in_reg_dst    = ctl[5];
    in_alu_src    = ctl[4];
    in_mem_read   = ctl[3];
    in_mem_write  = ctl[2];
    in_reg_write  = ctl[1];
    in_mem_to_reg = ctl[0];
  endtask

  task automatic test_reset();
    set_instr(6'h00, 6'h20, 32'd1, 32'd2, 32'd0, 5'd1, 5'd2, 5'd3, 6'b100010);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    in_valid = 1'b0;
    checks++;
    if (ex_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid got %0b want 0", ex_valid); end
    checks++;
    if (alu_op !== 3'd0) begin errors++; $display("[TB] FAIL reset_alu_op got %0d want 0", alu_op); end
    checks++;
    if ({alu_a, alu_b, ex_reg_write, ex_mem_read} !== '0) begin
      errors++; $display("[TB] FAIL reset_data a=%h b=%h rw=%0b mr=%0b want all 0", alu_a, alu_b, ex_reg_write, ex_mem_read);
    end
  endtask

  task automatic test_add();
    set_instr(6'h00, 6'h20, 32'd5, 32'd7, 32'h1234, 5'd1, 5'd2, 5'd4, 6'b100010);
    tick();
    checks++;
    if (ex_valid !== 1'b1) begin errors++; $display("[TB] FAIL add_valid got %0b want 1", ex_valid); end
    checks++;
    if (alu_op !== 3'd2) begin errors++; $display("[TB] FAIL add_alu_op got %0d want 2", alu_op); end
    checks++;
    if (alu_a !== 32'd5 || alu_b !== 32'd7) begin errors++; $display("[TB] FAIL add_operands a=%0d b=%0d want 5 7", alu_a, alu_b); end
    checks++;
    if (ex_reg_write !== 1'b1 || ex_dst !== 5'd4 || ex_illegal !== 1'b0) begin
      errors++; $display("[TB] FAIL add_ctrl rw=%0b dst=%0d ill=%0b want 1 4 0", ex_reg_write, ex_dst, ex_illegal);
    end
    checks++;
    if (ex_store_data !== 32'd7 || ex_rs !== 5'd1 || ex_rt !== 5'd2) begin
      errors++; $display("[TB] FAIL add_fields sd=%0d rs=%0d rt=%0d want 7 1 2", ex_store_data, ex_rs, ex_rt);
    end
  endtask

  task automatic test_lw();
    set_instr(6'h23, 6'h3F, 32'h100, 32'h55, 32'hFFFF_FFFC, 5'd8, 5'd9, 5'd3, 6'b011011);
    tick();
    checks++;
    if (alu_op !== 3'd2) begin errors++; $display("[TB] FAIL lw_alu_op got %0d want 2", alu_op); end
    checks++;
    if (alu_b !== 32'hFFFF_FFFC || alu_a !== 32'h100) begin errors++; $display("[TB] FAIL lw_operands a=%h b=%h want 100 fffffffc", alu_a, alu_b); end
    checks++;
    if (ex_dst !== 5'd9) begin errors++; $display("[TB] FAIL lw_dst got %0d want 9", ex_dst); end
    checks++;
    if (ex_mem_read !== 1'b1 || ex_mem_to_reg !== 1'b1 || ex_mem_write !== 1'b0) begin
      errors++; $display("[TB] FAIL lw_ctrl mr=%0b m2r=%0b mw=%0b want 1 1 0", ex_mem_read, ex_mem_to_reg, ex_mem_write);
    end
    checks++;
    if (ex_store_data !== 32'h55) begin errors++; $display("[TB] FAIL lw_store_data got %h want 55", ex_store_data); end
  endtask

  task automatic test_decode();
    logic [5:0] ops  [10] = '{6'h00, 6'h00, 6'h00, 6'h00, 6'h2B, 6'h08, 6'h04, 6'h0C, 6'h0D, 6'h0A};
    logic [5:0] fns  [10] = '{6'h24, 6'h25, 6'h22, 6'h2A, 6'h00, 6'h11, 6'h00, 6'h00, 6'h00, 6'h00};
    logic [2:0] exp  [10] = '{3'd0,  3'd1,  3'd3,  3'd4,  3'd2,  3'd2,  3'd3,  3'd0,  3'd1,  3'd4};
    for (int i = 0; i < 10; i++) begin
      set_instr(ops[i], fns[i], 32'd10, 32'd20, 32'd3, 5'd1, 5'd2, 5'd3, 6'b100010);
      tick();
      checks++;
      if (alu_op !== exp[i] || ex_illegal !== 1'b0 || ex_valid !== 1'b1) begin
        errors++; $display("[TB] FAIL decode_%0d op=%h fn=%h got alu_op=%0d ill=%0b v=%0b want %0d 0 1", i, ops[i], fns[i], alu_op, ex_illegal, ex_valid, exp[i]);
      end
    end
  endtask

  task automatic test_stall();
    set_instr(6'h00, 6'h2A, 32'd1, 32'd2, 32'd0, 5'd1, 5'd2, 5'd6, 6'b100010);
    tick();
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      set_instr(6'h00, 6'h20, 32'd99 + i, 32'd50, 32'd0, 5'd7, 5'd8, 5'd9, 6'b100010);
      tick();
      checks++;
      if (alu_op !== 3'd4 || alu_a !== 32'd1 || alu_b !== 32'd2 || ex_dst !== 5'd6 || ex_valid !== 1'b1) begin
        errors++; $display("[TB] FAIL stall_hold_%0d op=%0d a=%0d b=%0d dst=%0d v=%0b want 4 1 2 6 1", i, alu_op, alu_a, alu_b, ex_dst, ex_valid);
      end
    end
    stall = 1'b0;
    tick();
    checks++;
    if (alu_op !== 3'd2 || alu_a !== 32'd101 || ex_dst !== 5'd9) begin
      errors++; $display("[TB] FAIL stall_release op=%0d a=%0d dst=%0d want 2 101 9", alu_op, alu_a, ex_dst);
    end
  endtask

  task automatic test_flush_and_reset_in_stall();
    set_instr(6'h00, 6'h20, 32'd3, 32'd4, 32'd0, 5'd1, 5'd2, 5'd5, 6'b100010);
    tick();
    stall = 1'b1;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    stall = 1'b0;
    checks++;
    if (ex_valid !== 1'b0 || ex_reg_write !== 1'b0 || alu_op !== 3'd0 || alu_a !== '0 || ex_dst !== '0) begin
      errors++; $display("[TB] FAIL flush_stall v=%0b rw=%0b op=%0d a=%0d dst=%0d want all 0", ex_valid, ex_reg_write, alu_op, alu_a, ex_dst);
    end
    set_instr(6'h23, 6'h00, 32'd8, 32'd9, 32'd4, 5'd1, 5'd2, 5'd5, 6'b011011);
    tick();
    stall = 1'b1;
    tick();
    checks++;
    if (ex_valid !== 1'b1 || ex_mem_read !== 1'b1) begin
      errors++; $display("[TB] FAIL stall_before_rst v=%0b mr=%0b want 1 1", ex_valid, ex_mem_read);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    stall = 1'b0;
    checks++;
    if (ex_valid !== 1'b0 || ex_mem_read !== 1'b0 || ex_reg_write !== 1'b0 || ex_mem_to_reg !== 1'b0 || alu_b !== '0) begin
      errors++; $display("[TB] FAIL rst_in_stall v=%0b mr=%0b rw=%0b m2r=%0b b=%0d want all 0", ex_valid, ex_mem_read, ex_reg_write, ex_mem_to_reg, alu_b);
    end
  endtask

  task automatic test_bubble();
    set_instr(6'h00, 6'h22, 32'd3, 32'd4, 32'd0, 5'd1, 5'd2, 5'd5, 6'b100010);
    tick();
    in_valid = 1'b0;
    tick();
    checks++;
    if (ex_valid !== 1'b0 || alu_op !== 3'd0 || alu_a !== '0 || alu_b !== '0 || ex_reg_write !== 1'b0) begin
      errors++; $display("[TB] FAIL bubble v=%0b op=%0d a=%0d b=%0d rw=%0b want all 0", ex_valid, alu_op, alu_a, alu_b, ex_reg_write);
    end
  endtask

  task automatic test_illegal();
    set_instr(6'h00, 6'h27, 32'd3, 32'd4, 32'd0, 5'd1, 5'd2, 5'd5, 6'b101110);
    tick();
    checks++;
    if (ex_illegal !== 1'b1 || alu_op !== 3'd2 || ex_valid !== 1'b1) begin
      errors++; $display("[TB] FAIL illegal_nor ill=%0b op=%0d v=%0b want 1 2 1", ex_illegal, alu_op, ex_valid);
    end
    checks++;
    if (ex_reg_write !== 1'b0 || ex_mem_read !== 1'b0 || ex_mem_write !== 1'b0) begin
      errors++; $display("[TB] FAIL illegal_ctrl rw=%0b mr=%0b mw=%0b want 0 0 0", ex_reg_write, ex_mem_read, ex_mem_write);
    end
    set_instr(6'h3F, 6'h20, 32'd3, 32'd4, 32'd0, 5'd1, 5'd2, 5'd5, 6'b000110);
    tick();
    checks++;
    if (ex_illegal !== 1'b1 || alu_op !== 3'd2 || ex_mem_write !== 1'b0 || ex_reg_write !== 1'b0) begin
      errors++; $display("[TB] FAIL illegal_opcode ill=%0b op=%0d mw=%0b rw=%0b want 1 2 0 0", ex_illegal, alu_op, ex_mem_write, ex_reg_write);
    end
  endtask

`ifdef ID_EX_FWD_EN
  task automatic test_forwarding();
    set_instr(6'h00, 6'h20, 32'h11, 32'h22, 32'h0, 5'd3, 5'd4, 5'd5, 6'b100010);
    tick();
    in_valid  = 1'b0;
    fwd_m_we = 1'b1; fwd_m_dst = 5'd3; fwd_m_data = 32'hAA;
    fwd_w_we = 1'b1; fwd_w_dst = 5'd3; fwd_w_data = 32'hBB;
    #1;
    checks++;
    if (alu_a !== 32'hAA || alu_b !== 32'h22) begin errors++; $display("[TB] FAIL fwd_m_priority a=%h b=%h want aa 22", alu_a, alu_b); end
    fwd_m_dst = 5'd0; fwd_w_dst = 5'd0;
    #1;
    checks++;
    if (alu_a !== 32'h11) begin errors++; $display("[TB] FAIL fwd_r0 a=%h want 11", alu_a); end
    fwd_m_we = 1'b0; fwd_w_dst = 5'd4;
    #1;
    checks++;
    if (alu_b !== 32'hBB || ex_store_data !== 32'hBB || alu_a !== 32'h11) begin
      errors++; $display("[TB] FAIL fwd_w_rt a=%h b=%h sd=%h want 11 bb bb", alu_a, alu_b, ex_store_data);
    end
    fwd_w_we = 1'b0;
    tick();
  endtask
`endif

  initial begin
    $display("[TB] starting id_ex_stage bench");
    test_reset();
    test_add();
    test_lw();
    test_decode();
    test_stall();
    test_flush_and_reset_in_stall();
    test_bubble();
    test_illegal();
`ifdef ID_EX_FWD_EN
    test_forwarding();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
